// File: rtl/screen_draw_ctrl_pkg.sv
// Shared types and constants for the screen/sprite draw sequencer.
// Contents:
//   drawState_t      - sequencer states IDLE, DRAW, FLUSH, DONE
//   VGA_X_W/VGA_Y_W  - VGA coordinate widths
//   ADDR_W/COLOR_W   - ROM address and colour widths
//   *_DFLT           - default screen/sprite geometry and transparent colour
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drawState_t;

    localparam int VGA_X_W = 8;
    localparam int VGA_Y_W = 7;
    localparam int ADDR_W  = 15;
    localparam int COLOR_W = 3;

    localparam int SCREEN_W_DFLT = 160;
    localparam int SCREEN_H_DFLT = 120;
    localparam int SPRITE_W_DFLT = 40;
    localparam int SPRITE_H_DFLT = 40;

    localparam logic [COLOR_W-1:0] TRANSPARENT_DFLT = 3'b101;

endpackage

// File: rtl/screen_draw_ctrl_if.sv
// Bundle between the game control/datapath side and the draw sequencer.
// Signals:
//   start, sel_sprite, x_origin, y_origin, trans_en - draw request and its arguments
//   rom_color                                        - ROM/colour-mux data, one cycle after rom_addr
//   rom_addr                                         - linear row-major ROM address
//   x, y, color, plot                                - VGA adapter write port
//   busy, done                                       - handshake status back to the game FSM
// Modports:
//   master - requester / ROM side (drives request and rom_color)
//   slave  - the draw sequencer
interface screen_draw_ctrl_if;
    import draw_pkg::*;

    logic                 start;
    logic                 sel_sprite;
    logic [VGA_X_W-1:0]   x_origin;
    logic [VGA_Y_W-1:0]   y_origin;
    logic                 trans_en;
    logic [COLOR_W-1:0]   rom_color;
    logic [ADDR_W-1:0]    rom_addr;
    logic [VGA_X_W-1:0]   x;
    logic [VGA_Y_W-1:0]   y;
    logic [COLOR_W-1:0]   color;
    logic                 plot;
    logic                 busy;
    logic                 done;

    modport master (
        output start, sel_sprite, x_origin, y_origin, trans_en, rom_color,
        input  rom_addr, x, y, color, plot, busy, done
    );

    modport slave (
        input  start, sel_sprite, x_origin, y_origin, trans_en, rom_color,
        output rom_addr, x, y, color, plot, busy, done
    );

endinterface

// File: rtl/screen_draw_ctrl_scan.sv
// xy_scan_counter: row-major column/row walker with runtime size select.
// Ports:
//   clk, resetn        - clock, synchronous active-low reset
//   clr                - zero column, row and address
//   en                 - advance one pixel
//   selSprite          - 0 = screen size, 1 = sprite size
//   c, r               - current column / row
//   addr               - linear address r*W + c
//   last               - current position is the final pixel (c=W-1, r=H-1)
module xy_scan_counter
    import draw_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DFLT,
    parameter int SCREEN_H = SCREEN_H_DFLT,
    parameter int SPRITE_W = SPRITE_W_DFLT,
    parameter int SPRITE_H = SPRITE_H_DFLT
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clr,
    input  logic               en,
    input  logic               selSprite,
    output logic [VGA_X_W-1:0] c,
    output logic [VGA_Y_W-1:0] r,
    output logic [ADDR_W-1:0]  addr,
    output logic               last
);

    localparam logic [VGA_X_W-1:0] SCR_LAST_C = VGA_X_W'(SCREEN_W - 1);
    localparam logic [VGA_Y_W-1:0] SCR_LAST_R = VGA_Y_W'(SCREEN_H - 1);
    localparam logic [VGA_X_W-1:0] SPR_LAST_C = VGA_X_W'(SPRITE_W - 1);
    localparam logic [VGA_Y_W-1:0] SPR_LAST_R = VGA_Y_W'(SPRITE_H - 1);

    logic lastCol;
    logic lastRow;

    assign lastCol = (c == (selSprite ? SPR_LAST_C : SCR_LAST_C));
    assign lastRow = (r == (selSprite ? SPR_LAST_R : SCR_LAST_R));
    assign last    = lastCol && lastRow;

    // Row-major order makes the linear address a plain incrementer, so no
    // r*W multiply is needed.
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            c    <= '0;
            r    <= '0;
            addr <= '0;
        end else if (en) begin
            addr <= addr + 1'b1;
            if (lastCol) begin
                c <= '0;
                r <= r + 1'b1;
            end else begin
                c <= c + 1'b1;
            end
        end
    end

endmodule

// File: rtl/screen_draw_ctrl.sv
// screen_draw_ctrl: pixel-walk sequencer feeding the VGA adapter.
// Issues row-major ROM addresses for a full screen or a sprite, realigns
// x/y with the one-cycle ROM latency, and gates plot for clipping and
// the transparent colour.
// Ports:
//   clk     - system clock, rising edge
//   resetn  - synchronous active-low reset
//   bus     - screen_draw_ctrl_if.slave: request/handshake, ROM port, VGA port
module screen_draw_ctrl
    import draw_pkg::*;
#(
    parameter int                 SCREEN_W    = SCREEN_W_DFLT,
    parameter int                 SCREEN_H    = SCREEN_H_DFLT,
    parameter int                 SPRITE_W    = SPRITE_W_DFLT,
    parameter int                 SPRITE_H    = SPRITE_H_DFLT,
    parameter logic [COLOR_W-1:0] TRANSPARENT = TRANSPARENT_DFLT
) (
    input  logic              clk,
    input  logic              resetn,
    screen_draw_ctrl_if.slave bus
);

    localparam logic [VGA_X_W:0] X_MAX = (VGA_X_W + 1)'(SCREEN_W - 1);
    localparam logic [VGA_Y_W:0] Y_MAX = (VGA_Y_W + 1)'(SCREEN_H - 1);

    drawState_t         state;
    logic               selSpriteQ;
    logic               transEnQ;
    logic [VGA_X_W-1:0] xOriginQ;
    logic [VGA_Y_W-1:0] yOriginQ;
    logic               busyQ;
    logic               doneQ;

    logic               cntClr;
    logic               cntEn;
    logic [VGA_X_W-1:0] c;
    logic [VGA_Y_W-1:0] r;
    logic [ADDR_W-1:0]  addr;
    logic               last;

    logic               vld_p1;
    logic [VGA_X_W:0]   xSum_p1;
    logic [VGA_Y_W:0]   ySum_p1;
    logic               clipped;
    logic               transHit;

    assign cntClr = (state == IDLE) && bus.start;
    // Holding the counter on the final pixel keeps rom_addr at its last
    // value through FLUSH.
    assign cntEn  = (state == DRAW) && !last;

    xy_scan_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) uScan (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (cntClr),
        .en        (cntEn),
        .selSprite (selSpriteQ),
        .c         (c),
        .r         (r),
        .addr      (addr),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            busyQ      <= 1'b0;
            doneQ      <= 1'b0;
            selSpriteQ <= 1'b0;
            transEnQ   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    doneQ <= 1'b0;
                    if (bus.start) begin
                        selSpriteQ <= bus.sel_sprite;
                        transEnQ   <= bus.trans_en;
                        busyQ      <= 1'b1;
                        state      <= DRAW;
                    end
                end
                DRAW: begin
                    if (last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    busyQ <= 1'b0;
                    doneQ <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    doneQ <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busyQ <= 1'b0;
                    doneQ <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Origins are pure data; they only matter once a start has latched them.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && bus.start) begin
            xOriginQ <= bus.x_origin;
            yOriginQ <= bus.y_origin;
        end
    end

    // ---- stage p1: coordinates of the address issued last cycle, aligned
    // with rom_color arriving from the synchronous ROM ----
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p1  <= 1'b0;
            xSum_p1 <= '0;
            ySum_p1 <= '0;
        end else begin
            vld_p1  <= (state == DRAW);
            // One extra bit so an origin near the right/bottom edge is
            // detected as off-screen rather than wrapping.
            xSum_p1 <= {1'b0, xOriginQ} + {1'b0, c};
            ySum_p1 <= {1'b0, yOriginQ} + {1'b0, r};
        end
    end

    assign clipped  = (xSum_p1 > X_MAX) || (ySum_p1 > Y_MAX);
    assign transHit = transEnQ && (bus.rom_color == TRANSPARENT);

    assign bus.rom_addr = addr;
    assign bus.x        = xSum_p1[VGA_X_W-1:0];
    assign bus.y        = ySum_p1[VGA_Y_W-1:0];
    assign bus.color    = bus.rom_color;
    assign bus.plot     = vld_p1 && !clipped && !transHit;
    assign bus.busy     = busyQ;
    assign bus.done     = doneQ;

endmodule

// File: tb/tb_screen_draw_ctrl.sv
// Directed bench for screen_draw_ctrl: sprite, full screen, clipping,
// transparency, ignored starts, back-to-back starts and mid-draw reset.
module tb_screen_draw_ctrl;
    import draw_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    screen_draw_ctrl_if bus();

    screen_draw_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int romMode = 0;
    logic [ADDR_W-1:0] romAddrHeld = '0;

    // ROM contents: mode 0 = low address bits, mode 1 = transparent on odd addresses.
    function automatic logic [COLOR_W-1:0] romF(input int a);
        if (romMode == 1) return (a % 2 == 1) ? 3'b101 : 3'b010;
        return COLOR_W'(a % 8);
    endfunction

    // Synchronous ROM: address seen mid-cycle, data appears after the next edge.
    always @(negedge clk) romAddrHeld = bus.rom_addr;
    always @(posedge clk) bus.rom_color = romF(int'(romAddrHeld));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drawAndCheck(input string tag, input bit sel, input int xo, input int yo,
                                input bit te, input int mode, input int pulseCyc, input bit pulseDone,
                                input int expPlots, input int efx, input int efy,
                                input int elx, input int ely);
        int W, H, N, k, xs, ys;
        int plots, addrErr, busyErr, busyCnt, donePulses, doneCyc, plotErr, pixErr, oddPlots;
        int fx, fy, lx, ly;
        logic [COLOR_W-1:0] col;
        logic expPlot;
        W = sel ? SPRITE_W_DFLT : SCREEN_W_DFLT;
        H = sel ? SPRITE_H_DFLT : SCREEN_H_DFLT;
        N = W * H;
        plots = 0; addrErr = 0; busyErr = 0; busyCnt = 0; donePulses = 0; doneCyc = -1;
        plotErr = 0; pixErr = 0; oddPlots = 0; fx = -1; fy = -1; lx = -1; ly = -1;
        romMode = mode;
        @(negedge clk);
        bus.start = 1'b1;
        bus.sel_sprite = sel;
        bus.x_origin = VGA_X_W'(xo);
        bus.y_origin = VGA_Y_W'(yo);
        bus.trans_en = te;
        for (int cyc = 1; cyc <= N + 2; cyc++) begin
            @(negedge clk);
            bus.start = (cyc == pulseCyc) || (pulseDone && cyc == N + 2);
            if (cyc == 1) begin
                // Request arguments change after acceptance; latched values must hold.
                bus.sel_sprite = ~sel;
                bus.x_origin = ~VGA_X_W'(xo);
                bus.y_origin = ~VGA_Y_W'(yo);
                bus.trans_en = ~te;
            end
            if (bus.busy !== (cyc <= N + 1)) busyErr++;
            if (bus.busy === 1'b1) busyCnt++;
            if (bus.done === 1'b1) begin
                donePulses++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            if (cyc <= N) begin
                if (bus.rom_addr !== ADDR_W'(cyc - 1)) addrErr++;
            end else if (cyc == N + 1) begin
                if (bus.rom_addr !== ADDR_W'(N - 1)) addrErr++;
            end
            expPlot = 1'b0;
            k = -1; xs = 0; ys = 0; col = '0;
            if (cyc >= 2 && cyc <= N + 1) begin
                k = cyc - 2;
                xs = xo + k % W;
                ys = yo + k / W;
                col = romF(k);
                expPlot = (xs <= 159) && (ys <= 119) && !(te && col == 3'b101);
            end
            if (bus.plot !== expPlot) plotErr++;
            if (bus.plot === 1'b1) begin
                plots++;
                if (k >= 0 && k % 2 == 1) oddPlots++;
                if (expPlot && (bus.x !== VGA_X_W'(xs) || bus.y !== VGA_Y_W'(ys) || bus.color !== col))
                    pixErr++;
                if (fx < 0) begin fx = int'(bus.x); fy = int'(bus.y); end
                lx = int'(bus.x); ly = int'(bus.y);
            end
        end
        chk($sformatf("%s plot count", tag), plots, expPlots);
        chk($sformatf("%s addr errors", tag), addrErr, 0);
        chk($sformatf("%s busy errors", tag), busyErr, 0);
        chk($sformatf("%s busy cycles", tag), busyCnt, N + 1);
        chk($sformatf("%s done cycle", tag), doneCyc, N + 2);
        chk($sformatf("%s done pulses", tag), donePulses, 1);
        chk($sformatf("%s plot errors", tag), plotErr, 0);
        chk($sformatf("%s pixel errors", tag), pixErr, 0);
        if (mode == 1) chk($sformatf("%s odd-address plots", tag), oddPlots, 0);
        chk($sformatf("%s first x", tag), fx, efx);
        chk($sformatf("%s first y", tag), fy, efy);
        chk($sformatf("%s last x", tag), lx, elx);
        chk($sformatf("%s last y", tag), ly, ely);
    endtask

    initial begin
        int idleErr;
        bus.start = 1'b0;
        bus.sel_sprite = 1'b0;
        bus.x_origin = '0;
        bus.y_origin = '0;
        bus.trans_en = 1'b0;

        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset rom_addr", bus.rom_addr, 0);
        chk("reset x", bus.x, 0);
        chk("reset y", bus.y, 0);
        chk("reset plot", bus.plot, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        resetn = 1'b1;

        // Sprite at (10,20), then a full screen started the cycle after done
        drawAndCheck("sprite10_20", 1'b1, 10, 20, 1'b0, 0, 0, 1'b0, 1600, 10, 20, 49, 59);
        drawAndCheck("screen0_0", 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 19200, 0, 0, 159, 119);

        // Clipped sprite: only the 20x20 on-screen corner plots
        drawAndCheck("clip140_100", 1'b1, 140, 100, 1'b0, 0, 0, 1'b0, 400, 140, 100, 159, 119);

        // Transparent skip on odd addresses
        drawAndCheck("trans0_0", 1'b1, 0, 0, 1'b1, 1, 0, 1'b0, 800, 0, 0, 38, 39);

        // Start pulses in DRAW and in DONE are ignored
        drawAndCheck("ignore5_5", 1'b1, 5, 5, 1'b0, 0, 300, 1'b1, 1600, 5, 5, 44, 44);
        @(negedge clk);
        bus.start = 1'b0;
        chk("after done-start busy", bus.busy, 0);
        chk("after done-start done", bus.done, 0);

        // Reset during cycle 500 of a sprite draw
        romMode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.sel_sprite = 1'b1;
        bus.x_origin = 8'd10;
        bus.y_origin = 7'd20;
        bus.trans_en = 1'b0;
        for (int cyc = 1; cyc <= 500; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("pre-reset busy", bus.busy, 1);
        chk("pre-reset rom_addr", bus.rom_addr, 499);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid-reset plot", bus.plot, 0);
        chk("mid-reset busy", bus.busy, 0);
        chk("mid-reset rom_addr", bus.rom_addr, 0);
        chk("mid-reset done", bus.done, 0);
        resetn = 1'b1;
        idleErr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.plot !== 1'b0) idleErr++;
        end
        chk("post-reset idle", idleErr, 0);
        drawAndCheck("afterreset120_80", 1'b1, 120, 80, 1'b0, 0, 0, 1'b0, 1600, 120, 80, 159, 119);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/screen_draw_ctrl.md
Name: screen_draw_ctrl

Overview:
Pixel-walk sequencer that sits directly upstream of the game datapath's colour-select stage and the VGA adapter. It produces the ROM read address, compensates for the one-cycle synchronous ROM latency, and emits aligned x, y, colour and plot to the VGA adapter. On a start request it draws either a full 160x120 screen or a 40x40 sprite at a given origin, with optional transparent-colour skipping and off-screen clipping. The game control FSM drives it with a start/busy/done handshake.

Parameters:
SCREEN_W, 160, full-screen width in pixels
SCREEN_H, 120, full-screen height in pixels
SPRITE_W, 40, sprite width in pixels
SPRITE_H, 40, sprite height in pixels
TRANSPARENT, 3'b101, colour suppressed when trans_en is latched high

Ports:
clk  in  1  system clock; all logic is rising-edge
resetn  in  1  synchronous, active-low reset
start  in  1  draw request; sampled only in IDLE
sel_sprite  in  1  0 = full screen (SCREEN_W x SCREEN_H); 1 = sprite (SPRITE_W x SPRITE_H); latched on start
x_origin  in  8  top-left x; latched on start
y_origin  in  7  top-left y; latched on start
trans_en  in  1  enable transparent-colour skip; latched on start
rom_color  in  3  ROM/colour-mux output; valid one cycle after rom_addr is presented
rom_addr  out  15  linear row-major ROM address
x  out  8  VGA x of the pixel currently being plotted
y  out  7  VGA y of the pixel currently being plotted
color  out  3  VGA colour, driven as rom_color passed through
plot  out  1  VGA write enable
busy  out  1  high from the cycle after start is accepted through the FLUSH cycle
done  out  1  one-cycle pulse when a draw completes

Behaviour:
- Reset (resetn=0 at a clock edge): state=IDLE; column/row counters=0; rom_addr=0, x=0, y=0, plot=0, busy=0, done=0. This applies mid-draw: the draw is abandoned, no further plots occur and done is not pulsed.
- States: IDLE, DRAW, FLUSH, DONE.
- IDLE: on start=1, latch sel_sprite, x_origin, y_origin and trans_en; clear counters; go to DRAW.
- Start in any state other than IDLE is ignored, including DONE.
- DRAW: each cycle rom_addr = r*W + c, where W,H come from the latched size.
  - c increments each cycle; at c=W-1, c wraps to 0 and r increments.
  - At c=W-1 and r=H-1 the next state is FLUSH.
  - Exactly W*H addresses are issued: 0..19199 for a screen, 0..1599 for a sprite.
- Alignment register: stage-1 holds valid, x = x_origin + c and y = y_origin + r for the address issued in the previous cycle.
  - color = rom_color (combinational pass-through).
  - plot = stage1_valid AND NOT clipped AND NOT (trans_en_latched AND rom_color == TRANSPARENT).
- Clipping:
  - Sums are computed 9 bits wide for x and 8 bits wide for y.
  - A pixel is clipped if x_sum > SCREEN_W-1 or y_sum > SCREEN_H-1.
  - Clipped pixels still consume a ROM address and a cycle, so timing is independent of origin.
  - Output x and y are the truncated sums; they are don't-care when plot=0.
- FLUSH: lasts one cycle and presents the last pixel. No new address is issued; rom_addr holds its last value. Next state is DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Timing (start sampled at edge 0):
  - DRAW occupies cycles 1..N with addresses 0..N-1.
  - Pixel k's plot candidate is in cycle k+2.
  - FLUSH is cycle N+1.
  - done is in cycle N+2.
  - busy is high in cycles 1..N+1.
- plot is 0 in IDLE and DONE and during cycle 1.

Decomposition:
- Package draw_pkg:
  - state enum {IDLE, DRAW, FLUSH, DONE}
  - VGA_X_W=8, VGA_Y_W=7, ADDR_W=15, COLOR_W=3
  - screen and sprite dimension constants
  - TRANSPARENT default
- One sub-module, xy_scan_counter:
  - column/row counter with runtime W/H select, clear and enable
  - outputs c, r, linear address and a last flag
- The top level holds the FSM, origin/size latches, alignment register and plot gating.

Test Plan:
- Sprite at (10,20), trans_en=0, start at cycle 0 -> 1600 plots in cycles 2..1601. First plot is x=10, y=20 from addr 0; last plot is x=49, y=59 from addr 1599. done=1 in cycle 1602 only.
- Full screen at (0,0) -> rom_addr sweeps 0..19199 and 19200 plots occur. Last plot is x=159, y=119. done in cycle 19202; busy is high in cycles 1..19201.
- Sprite at (140,100) -> 1600 addresses are still issued but only 400 plots occur (x 140..159, y 100..119). done is still in cycle 1602.
- Sprite with trans_en=1 and a ROM model returning 3'b101 at every odd address -> exactly 800 plots, all at even addresses; timing unchanged.
- Start pulses during DRAW and during DONE -> ignored; only one done pulse per accepted start. A start in the cycle after done begins a fresh draw.
- resetn=0 during cycle 500 of a sprite draw -> next cycle plot=0, busy=0, rom_addr=0, state IDLE; no done pulse. A subsequent start draws the full 1600 pixels correctly.
